// File: rtl/uart_rx_frame.sv
// Oversampling UART receiver: start bit, LSB-first data, optional parity, one stop bit.
// Define UART_RX_MAJORITY_VOTE_EN to take each bit as a 2-of-3 vote around the bit centre.
module uart_rx_frame #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned PRESCALE   = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  RX_IN,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  output logic [DATA_WIDTH-1:0] P_DATA,
  output logic                  data_valid,
  output logic                  par_err,
  output logic                  stp_err
);

  localparam int unsigned CntW = $clog2(PRESCALE);
  localparam int unsigned BitW = $clog2(DATA_WIDTH + 1);
  localparam logic [CntW-1:0] CntLast = CntW'(PRESCALE - 1);
  localparam logic [CntW-1:0] CntMid  = CntW'(PRESCALE / 2);
  localparam logic [BitW-1:0] BitLast = BitW'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_e;

  state_e                state_q;
  logic [CntW-1:0]       edge_cnt_q;
  logic [CntW-1:0]       edge_cnt_nxt;
  logic [BitW-1:0]       bit_cnt_q;
  logic [DATA_WIDTH-1:0] shift_q;
  logic                  par_en_q;
  logic                  par_typ_q;
  logic                  par_bad_q;
  logic                  stop_q;
  logic                  cnt_last;
  logic                  smp_stb;
  logic                  smp_val;
  logic                  stop_now;
  logic                  par_exp;

  assign cnt_last     = (edge_cnt_q == CntLast);
  assign edge_cnt_nxt = cnt_last ? '0 : edge_cnt_q + CntW'(1);

`ifdef UART_RX_MAJORITY_VOTE_EN
  localparam logic [CntW-1:0] CntPre  = CntW'(PRESCALE / 2 - 1);
  localparam logic [CntW-1:0] CntPost = CntW'(PRESCALE / 2 + 1);

  logic [1:0] vote_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vote_q <= 2'b00;
    end else if (edge_cnt_q == CntPre) begin
      vote_q[0] <= RX_IN;
    end else if (edge_cnt_q == CntMid) begin
      vote_q[1] <= RX_IN;
    end
  end

  // Third vote is the live line value, so the decision lands one clock after the centre.
  assign smp_stb = (edge_cnt_q == CntPost);
  assign smp_val = (vote_q[0] & vote_q[1]) | (vote_q[0] & RX_IN) | (vote_q[1] & RX_IN);
`else
  assign smp_stb = (edge_cnt_q == CntMid);
  assign smp_val = RX_IN;
`endif

  // With a short prescale the stop decision can coincide with the last edge of the bit.
  assign stop_now = smp_stb ? smp_val : stop_q;
  assign par_exp  = (^shift_q) ^ par_typ_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      edge_cnt_q <= '0;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      par_en_q   <= 1'b0;
      par_typ_q  <= 1'b0;
      par_bad_q  <= 1'b0;
      stop_q     <= 1'b0;
      P_DATA     <= '0;
      data_valid <= 1'b0;
      par_err    <= 1'b0;
      stp_err    <= 1'b0;
    end else begin
      data_valid <= 1'b0;
      par_err    <= 1'b0;
      stp_err    <= 1'b0;
      unique case (state_q)
        StIdle: begin
          edge_cnt_q <= '0;
          if (!RX_IN) begin
            state_q    <= StStart;
            edge_cnt_q <= CntW'(1);
            bit_cnt_q  <= '0;
            par_en_q   <= PAR_EN;
            par_typ_q  <= PAR_TYP;
            par_bad_q  <= 1'b0;
          end
        end
        StStart: begin
          edge_cnt_q <= edge_cnt_nxt;
          if (smp_stb && smp_val) begin
            state_q    <= StIdle;
            edge_cnt_q <= '0;
          end else if (cnt_last) begin
            state_q <= StData;
          end
        end
        StData: begin
          edge_cnt_q <= edge_cnt_nxt;
          if (smp_stb) begin
            shift_q <= (shift_q >> 1) | (DATA_WIDTH'(smp_val) << (DATA_WIDTH - 1));
          end
          if (cnt_last) begin
            if (bit_cnt_q == BitLast) begin
              bit_cnt_q <= '0;
              state_q   <= par_en_q ? StParity : StStop;
            end else begin
              bit_cnt_q <= bit_cnt_q + BitW'(1);
            end
          end
        end
        StParity: begin
          edge_cnt_q <= edge_cnt_nxt;
          if (smp_stb) begin
            par_bad_q <= (smp_val != par_exp);
          end
          if (cnt_last) begin
            state_q <= StStop;
          end
        end
        StStop: begin
          edge_cnt_q <= edge_cnt_nxt;
          if (smp_stb) begin
            stop_q <= smp_val;
          end
          if (cnt_last) begin
            if (!par_bad_q && stop_now) begin
              P_DATA     <= shift_q;
              data_valid <= 1'b1;
            end
            par_err <= par_bad_q;
            stp_err <= !stop_now;
            state_q <= StIdle;
          end
        end
        default: begin
          state_q    <= StIdle;
          edge_cnt_q <= '0;
        end
      endcase
    end
  end

endmodule

// File: doc/uart_rx_frame.md
Name: uart_rx_frame

Overview:
- UART receiver: the counterpart of the team's UART transmit path (start bit, LSB-first data, optional parity, one stop bit).
- Oversamples the serial line RX_IN at PRESCALE clocks per bit and deserialises each frame into P_DATA.
- Checks parity and the stop bit, and emits a one-cycle data_valid strobe per good frame.
- Sits at the link input, directly feeding the downstream receive buffer.

Parameters:
- DATA_WIDTH, 8, number of data bits per frame (1..16).
- PRESCALE, 8, clocks per bit period; even, 4..32.

Ports:
- clk  input  1  system clock.
- rst  input  1  reset, asynchronous, active-high.
- RX_IN  input  1  serial line; idle high; assumed already synchronised to clk.
- PAR_EN  input  1  1 = frame carries a parity bit.
- PAR_TYP  input  1  0 = even parity, 1 = odd parity.
- P_DATA  output  DATA_WIDTH  last good received word.
- data_valid  output  1  one-cycle pulse when P_DATA is updated.
- par_err  output  1  one-cycle pulse: parity mismatch.
- stp_err  output  1  one-cycle pulse: stop bit sampled low.

Behaviour:
- Reset: all outputs 0, FSM in IDLE, edge counter 0, bit counter 0, shift register 0. Reset takes effect immediately, including mid-frame; the partial frame is discarded with no pulses.
- Edge counter runs 0..PRESCALE-1 within each bit period and wraps to 0 on entering the next bit. The sample point is edge_cnt == PRESCALE/2.
- IDLE: the first clock with RX_IN == 0 is edge 0 of the start bit.
  - Go to START with edge_cnt = 1.
  - Latch PAR_EN and PAR_TYP into internal registers; changes to these inputs mid-frame are ignored.
- START: at the sample point, if the sample is 1, treat it as a glitch: return to IDLE with no outputs. Otherwise, at edge_cnt == PRESCALE-1 go to DATA.
- DATA: at each sample point, shift the sample in LSB first. After DATA_WIDTH bit periods, go to PARITY if the latched PAR_EN is 1, else go to STOP.
- PARITY: at the sample point, compare the sample with the expected bit.
  - Even parity: expected bit = XOR of the data bits.
  - Odd parity: expected bit = inverse of that XOR.
  - Hold the mismatch flag internally.
  - At edge_cnt == PRESCALE-1, go to STOP.
- STOP: at the sample point, record the stop value. At edge_cnt == PRESCALE-1, on the next clock edge:
  - Parity OK and stop == 1: P_DATA <= shift register; data_valid = 1 for one cycle.
  - Parity mismatch: par_err = 1 for one cycle; P_DATA is unchanged.
  - Stop == 0: stp_err = 1 for one cycle; P_DATA is unchanged.
  - Both errors may pulse in the same cycle. data_valid never pulses in the same cycle as either error.
  - The FSM returns to IDLE in the same cycle.
- Back-to-back frames: a start bit beginning on the clock immediately after the stop period is detected in IDLE. No idle gap is needed.
- Break condition (line held low): each stop bit reads low, so stp_err pulses once per frame period and the FSM re-enters START immediately.
- Latency: data_valid rises at the clock edge ending the stop bit, which is (1 + DATA_WIDTH + PAR_EN + 1) × PRESCALE clocks after the start-bit edge 0.
- P_DATA holds its value until the next good frame.

Optional Feature:
- Macro: UART_RX_MAJORITY_VOTE_EN.
- Defined: each bit value is the 2-of-3 majority of RX_IN at edge_cnt PRESCALE/2-1, PRESCALE/2 and PRESCALE/2+1. The start-glitch check, data, parity and stop all use the voted value; the decision is effective after the +1 sample. Frame timing and output timing are unchanged.
- Undefined: a single sample at PRESCALE/2; no extra sample registers.

Test Plan:
- PRESCALE=8, PAR_EN=0, frame 0xA5 sent LSB first with stop=1 -> data_valid pulses one cycle, exactly 80 clocks after start edge 0; P_DATA=0xA5; par_err=0, stp_err=0.
- PAR_EN=1, PAR_TYP=0, 0xA5 with parity bit 0 -> P_DATA=0xA5 with data_valid. Repeat with parity bit 1 -> par_err pulse, no data_valid, P_DATA stays 0xA5.
- PAR_EN=1, PAR_TYP=1, 0x3C with parity bit 1 -> valid. Same frame with stop=0 -> stp_err pulse only, P_DATA unchanged.
- RX_IN low for 3 clocks then high -> no output pulses; FSM back in IDLE. A following 0x5A frame is received correctly.
- Two back-to-back frames 0x01 then 0xFE with no idle gap -> two data_valid pulses 80 clocks apart with the correct P_DATA each time. Assert rst mid-way through a third frame -> all outputs 0 immediately, no pulses.
- With UART_RX_MAJORITY_VOTE_EN, a 1-clock low glitch at the centre of a data bit set to 1 -> bit still reads 1; P_DATA is correct. Without the macro -> that bit reads 0.
